// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame levels and a baud-rate helper.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

  // Rounded clock cycles per serial bit for a given clock and baud rate.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO; a push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter; queued bytes leave back-to-back with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  tx_state_e      state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [IdxW-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            serial_q, serial_d;
  logic            active_q, active_d;
  logic            done_q, done_d;

  logic       fifo_full, fifo_empty, push, pop, bit_end;
  logic [7:0] fifo_dout;

  assign o_Tx_Ready  = !fifo_full;
  assign push        = i_Tx_DV && o_Tx_Ready;
  assign bit_end     = (clk_cnt_q == CntLast);
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (i_Tx_Byte),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= IDLE_LEVEL;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_dout;
          bit_idx_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IdxW'(1);
          if (bit_idx_q == IdxLast) state_d = StStop;
        end
      end
      StStop: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_dout;
            bit_idx_d = '0;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line outputs follow the current state one edge later, so they stay glitch-free.
  always_comb begin
    serial_d = IDLE_LEVEL;
    active_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        serial_d = IDLE_LEVEL;
      end
      StStart: begin
        serial_d = START_LEVEL;
        active_d = 1'b1;
      end
      StData: begin
        serial_d = shift_q[0];
        active_d = 1'b1;
      end
      StStop: begin
        serial_d = STOP_LEVEL;
        active_d = 1'b1;
        done_d   = bit_end;
      end
      default: serial_d = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a line decoder that recovers transmitted bytes.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  int         n_tests;
  int         n_fail;
  logic [7:0] rx_q[$];
  int         rx_ferr;
  int         done_cnt;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Tx_DV     (tx_dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Ready  (tx_ready),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Active (tx_active),
    .o_Tx_Done   (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line decoder: find the start bit, then sample each bit at its centre.
  initial begin : rx_model
    logic [7:0] sh;
    rx_ferr = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_serial === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          sh[k] = tx_serial;
        end
        repeat (CPB) @(negedge clk);
        if (tx_serial !== 1'b1) rx_ferr++;
        rx_q.push_back(sh);
      end
    end
  end

  initial begin : done_counter
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_dv   = 1'b1;
    tx_byte = b;
    tick();
    tx_dv   = 1'b0;
  endtask

  function automatic logic exp_level(input logic [7:0] b, input int p);
    int bi;
    bi = p / CPB;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[bi-1];
  endfunction

  // Samples nfr frames cycle by cycle, starting on the edge after the current one.
  task automatic capture(input logic [7:0] b0, input logic [7:0] b1, input int nfr);
    logic [7:0] b;
    int         p;
    for (int c = 0; c < nfr * FRAME; c++) begin
      tick();
      p = c % FRAME;
      b = (c < FRAME) ? b0 : b1;
      check("line", 32'(tx_serial), 32'(exp_level(b, p)));
      check("active", 32'(tx_active), 32'd1);
      check("done", 32'(tx_done), 32'(p == FRAME - 1));
    end
  endtask

  task automatic check_rx(input string tag, input int base, input logic [7:0] exp);
    logic [7:0] got;
    got = (base < rx_q.size()) ? rx_q[base] : 8'hxx;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin : main
    int   base;
    int   d0;
    int   lows;
    int   acts;
    logic [7:0] sim_bytes [6];

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    tx_dv   = 1'b0;
    tx_byte = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_serial", 32'(tx_serial), 32'd1);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    repeat (3) tick();

    // Single byte, exact line timing.
    base = rx_q.size();
    d0   = done_cnt;
    push_byte(8'hA5);
    tick();
    check("a5_latency", 32'(tx_serial), 32'd1);
    capture(8'hA5, 8'h00, 1);
    tick();
    check("a5_idle_line", 32'(tx_serial), 32'd1);
    check("a5_idle_active", 32'(tx_active), 32'd0);
    check("a5_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("a5_rx_cnt", 32'(rx_q.size() - base), 32'd1);
    check_rx("a5_rx", base, 8'hA5);
    repeat (5) tick();

    // Back-to-back frames with no idle gap.
    base = rx_q.size();
    d0   = done_cnt;
    push_byte(8'h00);
    push_byte(8'hFF);
    check("b2b_latency", 32'(tx_serial), 32'd1);
    capture(8'h00, 8'hFF, 2);
    tick();
    check("b2b_idle_active", 32'(tx_active), 32'd0);
    check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
    check_rx("b2b_rx0", base, 8'h00);
    check_rx("b2b_rx1", base + 1, 8'hFF);
    repeat (5) tick();

    // Flood: one byte pops at once, four fill the FIFO, the rest are dropped.
    base = rx_q.size();
    for (int i = 0; i < 8; i++) begin
      tx_dv   = 1'b1;
      tx_byte = 8'(i + 1);
      check("flood_ready", 32'(tx_ready), 32'(i < 5));
      tick();
    end
    tx_dv = 1'b0;
    repeat (5 * FRAME + 10) tick();
    check("flood_rx_cnt", 32'(rx_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) check_rx("flood_rx", base + i, 8'(i + 1));
    check("flood_idle", 32'(tx_active), 32'd0);
    repeat (5) tick();

    // Push and pop together at count 3: count must hold at 3.
    sim_bytes[0] = 8'h5A;
    sim_bytes[1] = 8'hC3;
    sim_bytes[2] = 8'h0F;
    sim_bytes[3] = 8'hF0;
    sim_bytes[4] = 8'h81;
    sim_bytes[5] = 8'h7E;
    base = rx_q.size();
    d0   = done_cnt;
    for (int i = 0; i < 4; i++) push_byte(sim_bytes[i]);
    repeat (FRAME - 3) tick();
    check("sim_ready_pre", 32'(tx_ready), 32'd1);
    push_byte(sim_bytes[4]);
    check("sim_done_align", 32'(tx_done), 32'd1);
    check("sim_ready_eq", 32'(tx_ready), 32'd1);
    push_byte(sim_bytes[5]);
    check("sim_full", 32'(tx_ready), 32'd0);
    repeat (6 * FRAME + 10) tick();
    check("sim_rx_cnt", 32'(rx_q.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) check_rx("sim_rx", base + i, sim_bytes[i]);
    check("sim_done_cnt", 32'(done_cnt - d0), 32'd6);
    repeat (5) tick();

    // Reset during bit 3 of 0x3C with two bytes queued.
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (16) tick();
    check("mid_bit3", 32'(tx_serial), 32'd1);
    check("mid_active", 32'(tx_active), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_serial", 32'(tx_serial), 32'd1);
    check("mid_rst_active", 32'(tx_active), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    lows = 0;
    acts = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (tx_serial !== 1'b1) lows++;
      if (tx_active !== 1'b0) acts++;
    end
    check("mid_no_tx_line", 32'(lows), 32'd0);
    check("mid_no_tx_active", 32'(acts), 32'd0);
    check("framing", 32'(rx_ferr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
